// File: rtl/softmax_csr_slave.sv
// AXI4-Lite register slave for the softmax engine: config registers, start/busy/done
// tracking, a config snapshot held for the datapath during a run, and a done interrupt.
module softmax_csr_slave #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TOKEN_W = 16,
  parameter int HEAD_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic [DATA_W-1:0]     cfg_in_base,
  output logic [DATA_W-1:0]     cfg_in_head_stride,
  output logic [DATA_W-1:0]     cfg_in_line_stride,
  output logic [DATA_W-1:0]     cfg_out_base,
  output logic [DATA_W-1:0]     cfg_out_head_stride,
  output logic [DATA_W-1:0]     cfg_out_line_stride,
  output logic [TOKEN_W-1:0]    cfg_token,
  output logic [HEAD_W-1:0]     cfg_head,
  output logic                  cfg_kv_cache,
  output logic                  cfg_need_mask,
  output logic                  start,
  input  logic                  done_in,
  output logic                  irq
);

  localparam logic [ADDR_W-3:0] OFF_CTRL     = 'h0;
  localparam logic [ADDR_W-3:0] OFF_STATUS   = 'h1;
  localparam logic [ADDR_W-3:0] OFF_IN_BASE  = 'h2;
  localparam logic [ADDR_W-3:0] OFF_IN_HS    = 'h3;
  localparam logic [ADDR_W-3:0] OFF_IN_LS    = 'h4;
  localparam logic [ADDR_W-3:0] OFF_OUT_BASE = 'h5;
  localparam logic [ADDR_W-3:0] OFF_OUT_HS   = 'h6;
  localparam logic [ADDR_W-3:0] OFF_OUT_LS   = 'h7;
  localparam logic [ADDR_W-3:0] OFF_TOKEN    = 'h8;
  localparam logic [ADDR_W-3:0] OFF_HEAD     = 'h9;
  localparam logic [ADDR_W-3:0] OFF_MODE     = 'hA;
  localparam logic [ADDR_W-3:0] OFF_ID       = 'hB;
  localparam logic [DATA_W-1:0] ID_VALUE     = 32'h534D_5801;
  localparam logic [1:0]        RESP_OKAY    = 2'b00;
  localparam logic [1:0]        RESP_SLVERR  = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic                aw_held, w_held;
  logic [ADDR_W-1:0]   aw_addr;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;

  logic                irq_en, busy, done;
  logic [DATA_W-1:0]   in_base, in_head_stride, in_line_stride;
  logic [DATA_W-1:0]   out_base, out_head_stride, out_line_stride;
  logic [TOKEN_W-1:0]  token;
  logic [HEAD_W-1:0]   head;
  logic [1:0]          mode;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_val,
                                              input logic [DATA_W-1:0] new_val,
                                              input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Write decode on the held AW/W beats; evaluated only when both are held.
  logic [ADDR_W-3:0] w_off;
  logic              wr_cfg, wr_start, wr_err;

  always_comb begin
    w_off    = aw_addr[ADDR_W-1:2];
    wr_cfg   = (w_off >= OFF_IN_BASE) && (w_off <= OFF_MODE);
    wr_start = (w_off == OFF_CTRL) && w_strb[0] && w_data[0];
    wr_err   = (w_off > OFF_ID) || (wr_cfg && busy) || (wr_start && busy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state             <= W_IDLE;
      s_awready           <= 1'b0;
      s_wready            <= 1'b0;
      s_bvalid            <= 1'b0;
      s_bresp             <= RESP_OKAY;
      aw_held             <= 1'b0;
      w_held              <= 1'b0;
      aw_addr             <= '0;
      w_data              <= '0;
      w_strb              <= '0;
      irq_en              <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      in_base             <= '0;
      in_head_stride      <= '0;
      in_line_stride      <= '0;
      out_base            <= '0;
      out_head_stride     <= '0;
      out_line_stride     <= '0;
      token               <= '0;
      head                <= '0;
      mode                <= '0;
      cfg_in_base         <= '0;
      cfg_in_head_stride  <= '0;
      cfg_in_line_stride  <= '0;
      cfg_out_base        <= '0;
      cfg_out_head_stride <= '0;
      cfg_out_line_stride <= '0;
      cfg_token           <= '0;
      cfg_head            <= '0;
      cfg_kv_cache        <= 1'b0;
      cfg_need_mask       <= 1'b0;
      start               <= 1'b0;
    end else begin
      start <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (s_awvalid && s_awready) begin
            aw_addr <= s_awaddr;
            aw_held <= 1'b1;
          end
          if (s_wvalid && s_wready) begin
            w_data <= s_wdata;
            w_strb <= s_wstrb;
            w_held <= 1'b1;
          end
          s_awready <= !(aw_held || (s_awvalid && s_awready));
          s_wready  <= !(w_held || (s_wvalid && s_wready));
          if (aw_held && w_held) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            s_bvalid <= 1'b1;
            s_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            w_state  <= W_RESP;
            if (!wr_err) begin
              case (w_off)
                OFF_CTRL: begin
                  if (w_strb[0]) irq_en <= w_data[1];
                  if (wr_start) begin
                    start               <= 1'b1;
                    busy                <= 1'b1;
                    done                <= 1'b0;
                    cfg_in_base         <= in_base;
                    cfg_in_head_stride  <= in_head_stride;
                    cfg_in_line_stride  <= in_line_stride;
                    cfg_out_base        <= out_base;
                    cfg_out_head_stride <= out_head_stride;
                    cfg_out_line_stride <= out_line_stride;
                    cfg_token           <= token;
                    cfg_head            <= head;
                    cfg_kv_cache        <= mode[0];
                    cfg_need_mask       <= mode[1];
                  end
                end
                OFF_STATUS:   if (w_strb[0] && w_data[1]) done <= 1'b0;
                OFF_IN_BASE:  in_base         <= merge(in_base, w_data, w_strb);
                OFF_IN_HS:    in_head_stride  <= merge(in_head_stride, w_data, w_strb);
                OFF_IN_LS:    in_line_stride  <= merge(in_line_stride, w_data, w_strb);
                OFF_OUT_BASE: out_base        <= merge(out_base, w_data, w_strb);
                OFF_OUT_HS:   out_head_stride <= merge(out_head_stride, w_data, w_strb);
                OFF_OUT_LS:   out_line_stride <= merge(out_line_stride, w_data, w_strb);
                OFF_TOKEN:    token <= TOKEN_W'(merge(DATA_W'(token), w_data, w_strb));
                OFF_HEAD:     head  <= HEAD_W'(merge(DATA_W'(head), w_data, w_strb));
                OFF_MODE:     mode  <= 2'(merge(DATA_W'(mode), w_data, w_strb));
                default: ;
              endcase
            end
          end
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
      // Placed after the register writes so a coincident DONE clear loses to the set.
      if (done_in && busy) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  logic [ADDR_W-3:0] r_off;
  logic [DATA_W-1:0] rd_val;
  logic              rd_err;

  always_comb begin
    r_off  = s_araddr[ADDR_W-1:2];
    rd_val = '0;
    rd_err = 1'b0;
    case (r_off)
      OFF_CTRL:     rd_val = DATA_W'({irq_en, 1'b0});
      OFF_STATUS:   rd_val = DATA_W'({done, busy});
      OFF_IN_BASE:  rd_val = in_base;
      OFF_IN_HS:    rd_val = in_head_stride;
      OFF_IN_LS:    rd_val = in_line_stride;
      OFF_OUT_BASE: rd_val = out_base;
      OFF_OUT_HS:   rd_val = out_head_stride;
      OFF_OUT_LS:   rd_val = out_line_stride;
      OFF_TOKEN:    rd_val = DATA_W'(token);
      OFF_HEAD:     rd_val = DATA_W'(head);
      OFF_MODE:     rd_val = DATA_W'(mode);
      OFF_ID:       rd_val = ID_VALUE;
      default:      rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_arvalid && s_arready) begin
            s_rdata   <= rd_val;
            s_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            s_rvalid  <= 1'b1;
            s_arready <= 1'b0;
            r_state   <= R_DATA;
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign irq = done & irq_en;

endmodule

// File: tb/tb_softmax_csr_slave.sv
// Self-checking bench for softmax_csr_slave: register table, start/done/irq flow,
// busy protection, channel ordering, backpressure and asynchronous reset.
module tb_softmax_csr_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_awvalid, s_awready;
  logic [7:0]  s_awaddr;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [7:0]  s_araddr;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [31:0] cfg_in_base, cfg_in_head_stride, cfg_in_line_stride;
  logic [31:0] cfg_out_base, cfg_out_head_stride, cfg_out_line_stride;
  logic [15:0] cfg_token;
  logic [7:0]  cfg_head;
  logic        cfg_kv_cache, cfg_need_mask;
  logic        start, done_in, irq;

  softmax_csr_slave #(.ADDR_W(8), .DATA_W(32), .TOKEN_W(16), .HEAD_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .cfg_in_base(cfg_in_base), .cfg_in_head_stride(cfg_in_head_stride),
    .cfg_in_line_stride(cfg_in_line_stride), .cfg_out_base(cfg_out_base),
    .cfg_out_head_stride(cfg_out_head_stride), .cfg_out_line_stride(cfg_out_line_stride),
    .cfg_token(cfg_token), .cfg_head(cfg_head), .cfg_kv_cache(cfg_kv_cache),
    .cfg_need_mask(cfg_need_mask), .start(start), .done_in(done_in), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;
  vec_t vecs[13];

  always @(negedge clk) if (rst_n && start) start_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout, got no handshake expected one", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_ok, w_ok, b_ok;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    aw_ok = 0; w_ok = 0; b_ok = 0; resp = 2'bxx;
    for (int c = 0; c < 50 && !(aw_ok && w_ok); c++) begin
      @(negedge clk);
      if (s_awvalid && s_awready) aw_ok = 1;
      if (s_wvalid && s_wready) w_ok = 1;
      tick();
      if (aw_ok) s_awvalid = 1'b0;
      if (w_ok) s_wvalid = 1'b0;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b1;
    for (int c = 0; c < 50 && !b_ok; c++) begin
      @(negedge clk);
      if (s_bvalid) begin
        resp = s_bresp;
        b_ok = 1;
      end
      tick();
    end
    s_bready = 1'b0;
    if (!(aw_ok && w_ok && b_ok)) timeout_fail("write");
  endtask

  task automatic write_chk(input logic [7:0] addr, input logic [31:0] data,
                           input logic [1:0] exp_resp, input string name);
    logic [1:0] r;
    axi_write(addr, data, 4'hF, r);
    check(name, 32'(r), 32'(exp_resp));
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [31:0] ed,
                          input logic [1:0] er, input string name);
    exp_t e;
    bit a_ok, r_ok;
    e.data = ed; e.resp = er;
    sb.push_back(e);
    s_araddr = addr; s_arvalid = 1'b1;
    a_ok = 0; r_ok = 0;
    for (int c = 0; c < 50 && !a_ok; c++) begin
      @(negedge clk);
      if (s_arready) a_ok = 1;
      tick();
    end
    s_arvalid = 1'b0;
    s_rready = 1'b1;
    for (int c = 0; c < 50 && !r_ok; c++) begin
      @(negedge clk);
      if (s_rvalid) begin
        e = sb.pop_front();
        check({name, "_data"}, s_rdata, e.data);
        check({name, "_resp"}, 32'(s_rresp), 32'(e.resp));
        r_ok = 1;
      end
      tick();
    end
    s_rready = 1'b0;
    if (!r_ok) begin
      if (sb.size() > 0) void'(sb.pop_front());
      timeout_fail({name, "_read"});
    end
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    bit got;
    logic [1:0] r;

    vecs[0]  = '{8'h08, 32'h0000_0000, 4'hF, 2'b00, 32'h0000_0000, 2'b00};
    vecs[1]  = '{8'h0C, 32'h0000_4000, 4'hF, 2'b00, 32'h0000_4000, 2'b00};
    vecs[2]  = '{8'h10, 32'h0000_0400, 4'hF, 2'b00, 32'h0000_0400, 2'b00};
    vecs[3]  = '{8'h14, 32'h0800_0000, 4'hF, 2'b00, 32'h0800_0000, 2'b00};
    vecs[4]  = '{8'h18, 32'h1122_3344, 4'hF, 2'b00, 32'h1122_3344, 2'b00};
    vecs[5]  = '{8'h18, 32'hAABB_CCDD, 4'h4, 2'b00, 32'h11BB_3344, 2'b00};
    vecs[6]  = '{8'h1C, 32'h0000_0100, 4'hF, 2'b00, 32'h0000_0100, 2'b00};
    vecs[7]  = '{8'h20, 32'hABCD_0027, 4'hF, 2'b00, 32'h0000_0027, 2'b00};
    vecs[8]  = '{8'h24, 32'h0000_0102, 4'hF, 2'b00, 32'h0000_0002, 2'b00};
    vecs[9]  = '{8'h28, 32'hFFFF_FFFE, 4'hF, 2'b00, 32'h0000_0002, 2'b00};
    vecs[10] = '{8'h2C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h534D_5801, 2'b00};
    vecs[11] = '{8'h30, 32'h1234_5678, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
    vecs[12] = '{8'h23, 32'h0000_0027, 4'hF, 2'b00, 32'h0000_0027, 2'b00};

    rst_n = 1'b0;
    s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0;
    s_bready = 0; s_arvalid = 0; s_araddr = 0; s_rready = 0; done_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(s_awready), 0);
    check("rst_arready", 32'(s_arready), 0);
    check("rst_bvalid", 32'(s_bvalid), 0);
    check("rst_rvalid", 32'(s_rvalid), 0);
    check("rst_start_irq", 32'({start, irq}), 0);
    check("rst_rdata", s_rdata, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // Register table: write, check bresp, read back through the scoreboard.
    for (int i = 0; i < 13; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, r);
      check($sformatf("tbl%0d_bresp", i), 32'(r), 32'(vecs[i].bresp));
      axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp, $sformatf("tbl%0d", i));
    end
    axi_read(8'h0C, 32'h0000_4000, 2'b00, "tbl_recheck_0c");

    // Start, snapshot, busy protection, done, irq.
    s0 = start_cnt;
    write_chk(8'h00, 32'h1, 2'b00, "start_bresp");
    tick(); tick();
    check("start_pulses", 32'(start_cnt - s0), 1);
    check("cfg_token", 32'(cfg_token), 39);
    check("cfg_in_hs", cfg_in_head_stride, 32'h4000);
    check("cfg_out_base", cfg_out_base, 32'h0800_0000);
    check("cfg_head", 32'(cfg_head), 2);
    check("cfg_mode", 32'({cfg_need_mask, cfg_kv_cache}), 2);
    axi_read(8'h04, 32'h1, 2'b00, "status_busy");
    write_chk(8'h20, 32'h7, 2'b10, "busy_token_bresp");
    check("busy_cfg_token", 32'(cfg_token), 39);
    axi_read(8'h20, 32'd39, 2'b00, "busy_token_rd");
    s0 = start_cnt;
    write_chk(8'h00, 32'h1, 2'b10, "busy_start_bresp");
    tick(); tick();
    check("busy_no_start", 32'(start_cnt - s0), 0);
    repeat (80) tick();
    pulse_done();
    axi_read(8'h04, 32'h2, 2'b00, "status_done");
    @(negedge clk);
    check("irq_disabled", 32'(irq), 0);
    tick();
    write_chk(8'h00, 32'h2, 2'b00, "irq_en_bresp");
    @(negedge clk);
    check("irq_set", 32'(irq), 1);
    tick();
    axi_read(8'h00, 32'h2, 2'b00, "ctrl_rd");
    write_chk(8'h04, 32'h2, 2'b00, "w1c_bresp");
    axi_read(8'h04, 32'h0, 2'b00, "status_clr");
    @(negedge clk);
    check("irq_clr", 32'(irq), 0);
    tick();
    pulse_done();
    axi_read(8'h04, 32'h0, 2'b00, "idle_done_ignored");

    // DONE W1C and done_in in the same cycle: set wins.
    write_chk(8'h00, 32'h1, 2'b00, "start2_bresp");
    s_awaddr = 8'h04; s_wdata = 32'h2; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    check("race_ready", 32'({s_awready, s_wready}), 3);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; done_in = 1'b1;
    tick();
    done_in = 1'b0; s_bready = 1'b1;
    @(negedge clk);
    check("race_bvalid", 32'(s_bvalid), 1);
    tick();
    s_bready = 1'b0;
    axi_read(8'h04, 32'h2, 2'b00, "race_set_wins");
    write_chk(8'h04, 32'h2, 2'b00, "race_clr_bresp");

    // W three cycles ahead of AW, then bready held low for five cycles.
    s_wdata = 32'h5; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    check("wfirst_wready", 32'(s_wready), 1);
    tick();
    s_wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("wfirst_no_b", 32'(s_bvalid), 0);
      tick();
    end
    s_awaddr = 8'h24; s_awvalid = 1'b1;
    @(negedge clk);
    check("wfirst_awready", 32'(s_awready), 1);
    tick();
    s_awvalid = 1'b0;
    @(negedge clk);
    check("wfirst_b_latency", 32'(s_bvalid), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("bhold%0d", i), 32'({s_bvalid, s_bresp}), 32'b100);
    end
    tick();
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    @(negedge clk);
    check("bhold_release", 32'(s_bvalid), 0);
    tick();
    axi_read(8'h24, 32'h5, 2'b00, "wfirst_rd");

    // Same-cycle AW+W start with stalled B: exactly one commit.
    s0 = start_cnt;
    s_awaddr = 8'h00; s_wdata = 32'h1; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    check("same_ready", 32'({s_awready, s_wready}), 3);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("same_bvalid", 32'(s_bvalid), 1);
    check("same_one_start", 32'(start_cnt - s0), 1);
    tick();
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    axi_read(8'h04, 32'h1, 2'b00, "same_busy");
    pulse_done();
    write_chk(8'h04, 32'h2, 2'b00, "same_clr_bresp");

    // Random rready backpressure on an ID read: data must stay put.
    sb.push_back('{32'h534D_5801, 2'b00});
    s_araddr = 8'h2C; s_arvalid = 1'b1; s_rready = 1'b0;
    @(negedge clk);
    check("bp_arready", 32'(s_arready), 1);
    tick();
    s_arvalid = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      s_rready = (i >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_rvalid) begin
        check($sformatf("bp_rdata%0d", i), s_rdata, sb[0].data);
        if (s_rready) begin
          check("bp_rresp", 32'(s_rresp), 32'(sb[0].resp));
          void'(sb.pop_front());
          got = 1;
        end
      end
      tick();
    end
    s_rready = 1'b0;
    if (!got) begin
      void'(sb.pop_front());
      timeout_fail("bp_read");
    end

    // Asynchronous reset while BUSY with a read response pending.
    write_chk(8'h00, 32'h1, 2'b00, "rst_start_bresp");
    s_araddr = 8'h04; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    @(negedge clk);
    check("rst_rvalid_pending", 32'(s_rvalid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rvalid", 32'(s_rvalid), 0);
    check("arst_ready", 32'({s_awready, s_wready, s_arready}), 0);
    check("arst_cfg_token", 32'(cfg_token), 0);
    check("arst_rdata", s_rdata, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    axi_read(8'h04, 32'h0, 2'b00, "arst_status");
    axi_read(8'h20, 32'h0, 2'b00, "arst_token");
    axi_read(8'h0C, 32'h0, 2'b00, "arst_in_hs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
